// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between the instruction-fetch and data ports.
// One request is latched at a time. Simultaneous requests alternate between the two ports.
module mem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              RST,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;

    localparam logic [3:0] CNT_LAST = 4'(MEM_LAT - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              gnt_data_q, gnt_data_d;
    logic              last_data_q, last_data_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_ack_q, if_ack_d;
    logic              d_ack_q, d_ack_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              pick_data;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        gnt_data_d  = gnt_data_q;
        last_data_d = last_data_q;
        mem_en_d    = mem_en_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        // Data wins when it is the only requester or when fetch had the last grant
        pick_data   = d_req && (!if_req || !last_data_q);

        case (state_q)
            IDLE: begin
                if (if_req || d_req) begin
                    gnt_data_d  = pick_data;
                    last_data_d = pick_data;
                    cnt_d       = '0;
                    mem_en_d    = 1'b1;
                    state_d     = ACC;
                    if (pick_data) begin
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                    end
                end
            end
            ACC: begin
                if (mem_we_q || cnt_q == CNT_LAST) begin
                    if (!mem_we_q) begin
                        if (gnt_data_q) d_rdata_d  = mem_rdata;
                        else            if_rdata_d = mem_rdata;
                    end
                    mem_en_d = 1'b0;
                    mem_we_d = 1'b0;
                    d_ack_d  = gnt_data_q;
                    if_ack_d = !gnt_data_q;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            gnt_data_q  <= 1'b0;
            last_data_q <= 1'b0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            gnt_data_q  <= gnt_data_d;
            last_data_q <= last_data_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: each expected ack (port, cycle, both rdata regs) is queued at request time.
module tb_mem_arbiter;

    localparam int LAT = 2;

    typedef struct {
        bit          port;
        logic [31:0] exp_if;
        logic [31:0] exp_d;
        int          cyc;
    } sb_entry_t;

    logic        clk = 1'b0;
    logic        RST;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_ack, d_ack, mem_en, mem_we, busy;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    int          cyc = 0;
    logic [7:0]  en_run = '0;
    int          n_cmp = 0;
    int          n_err = 0;
    sb_entry_t   sb[$];
    logic [31:0] exp_if = '0;
    logic [31:0] exp_d  = '0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .RST(RST),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: read data is only valid in the last enabled cycle of an access
    always @(posedge clk) en_run <= mem_en ? en_run + 8'd1 : 8'd0;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        return (a == 32'h10) ? 32'hDEAD_BEEF : ((a * 32'h0101_0101) ^ 32'hC0DE_0000);
    endfunction

    assign mem_rdata = (mem_en && en_run == 8'(LAT - 1)) ? mem_val(mem_addr) : 32'hBAD0_BAD0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic expect_ack(input bit port, input bit we, input logic [31:0] addr, input int at_cyc);
        sb_entry_t e;
        if (!we) begin
            if (port) exp_d  = mem_val(addr);
            else      exp_if = mem_val(addr);
        end
        e.port   = port;
        e.exp_if = exp_if;
        e.exp_d  = exp_d;
        e.cyc    = at_cyc;
        sb.push_back(e);
    endtask

    task automatic wait_ack(input bit port);
        bit seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            seen = port ? d_ack : if_ack;
        end
        if (!seen) chk(port ? "d_ack_timeout" : "if_ack_timeout", 64'(seen), 64'd1);
    endtask

    always @(negedge clk) begin
        if (if_ack || d_ack) begin
            if (sb.size() == 0) begin
                chk("unexpected_ack", 64'({if_ack, d_ack}), 64'd0);
            end else begin
                sb_entry_t e;
                e = sb.pop_front();
                chk("ack_port",  64'({if_ack, d_ack}), e.port ? 64'd1 : 64'd2);
                chk("ack_cycle", 64'(cyc), 64'(e.cyc));
                chk("ack_if_rdata", 64'(if_rdata), 64'(e.exp_if));
                chk("ack_d_rdata",  64'(d_rdata),  64'(e.exp_d));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        if_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) @(negedge clk);
        RST = 1'b0;
        @(negedge clk);
        chk("rst_busy",      64'(busy), 64'd0);
        chk("rst_mem_en",    64'(mem_en), 64'd0);
        chk("rst_mem_we",    64'(mem_we), 64'd0);
        chk("rst_mem_addr",  64'(mem_addr), 64'd0);
        chk("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_acks",      64'({if_ack, d_ack}), 64'd0);
        chk("rst_if_rdata",  64'(if_rdata), 64'd0);
        chk("rst_d_rdata",   64'(d_rdata), 64'd0);

        // Single fetch read
        if_req = 1'b1; if_addr = 32'h10;
        expect_ack(1'b0, 1'b0, 32'h10, cyc + LAT + 1);
        @(negedge clk);
        chk("rd_c1_en",   64'(mem_en), 64'd1);
        chk("rd_c1_addr", 64'(mem_addr), 64'h10);
        chk("rd_c1_we",   64'(mem_we), 64'd0);
        chk("rd_c1_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("rd_c2_en",   64'(mem_en), 64'd1);
        chk("rd_c2_addr", 64'(mem_addr), 64'h10);
        wait_ack(1'b0);
        if_req = 1'b0;
        chk("rd_resp_en", 64'(mem_en), 64'd0);
        @(negedge clk);
        chk("rd_idle_busy", 64'(busy), 64'd0);
        chk("rd_hold_if",   64'(if_rdata), 64'hDEAD_BEEF);
        chk("rd_d_untouch", 64'(d_rdata), 64'd0);

        // Single data write
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'h1234_5678;
        expect_ack(1'b1, 1'b1, 32'h40, cyc + 2);
        @(negedge clk);
        chk("wr_en",    64'(mem_en), 64'd1);
        chk("wr_we",    64'(mem_we), 64'd1);
        chk("wr_addr",  64'(mem_addr), 64'h40);
        chk("wr_wdata", 64'(mem_wdata), 64'h1234_5678);
        wait_ack(1'b1);
        chk("wr_we_off", 64'(mem_we), 64'd0);
        chk("wr_en_off", 64'(mem_en), 64'd0);
        chk("wr_addr_hold", 64'(mem_addr), 64'h40);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);

        // Fresh reset so contention starts from last_grant = fetch
        RST = 1'b1;
        @(negedge clk);
        RST = 1'b0; exp_if = '0; exp_d = '0;
        chk("rst2_if_rdata", 64'(if_rdata), 64'd0);
        chk("rst2_d_rdata",  64'(d_rdata), 64'd0);

        // Contention: both held, reads; expect data, fetch, data, fetch
        if_req = 1'b1; if_addr = 32'h100;
        d_req  = 1'b1; d_addr  = 32'h200;
        expect_ack(1'b1, 1'b0, 32'h200, cyc + 1 * (LAT + 2) - 1);
        expect_ack(1'b0, 1'b0, 32'h100, cyc + 2 * (LAT + 2) - 1);
        expect_ack(1'b1, 1'b0, 32'h200, cyc + 3 * (LAT + 2) - 1);
        expect_ack(1'b0, 1'b0, 32'h100, cyc + 4 * (LAT + 2) - 1);
        wait_ack(1'b1);
        wait_ack(1'b0);
        wait_ack(1'b1);
        wait_ack(1'b0);
        if_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        chk("cont_idle_busy", 64'(busy), 64'd0);

        // Back-to-back data reads with address change right after the first ack
        d_req = 1'b1; d_addr = 32'h300;
        expect_ack(1'b1, 1'b0, 32'h300, cyc + LAT + 1);
        wait_ack(1'b1);
        d_addr = 32'h304;
        expect_ack(1'b1, 1'b0, 32'h304, cyc + 1 + LAT + 1);
        @(negedge clk);
        chk("b2b_idle_busy", 64'(busy), 64'd0);
        chk("b2b_hold1", 64'(d_rdata), 64'(mem_val(32'h300)));
        @(negedge clk);
        chk("b2b_new_addr", 64'(mem_addr), 64'h304);
        chk("b2b_hold2", 64'(d_rdata), 64'(mem_val(32'h300)));
        @(negedge clk);
        chk("b2b_hold3", 64'(d_rdata), 64'(mem_val(32'h300)));
        wait_ack(1'b1);
        d_req = 1'b0;
        @(negedge clk);

        // Write must leave d_rdata untouched
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h44; d_wdata = 32'hCAFE_F00D;
        expect_ack(1'b1, 1'b1, 32'h44, cyc + 2);
        wait_ack(1'b1);
        d_req = 1'b0; d_we = 1'b0;
        @(negedge clk);

        // Reset in the first ACC cycle of a read
        if_req = 1'b1; if_addr = 32'h500;
        @(negedge clk);
        chk("rma_acc_busy", 64'(busy), 64'd1);
        RST = 1'b1; if_req = 1'b0;
        @(negedge clk);
        chk("rma_busy",     64'(busy), 64'd0);
        chk("rma_mem_en",   64'(mem_en), 64'd0);
        chk("rma_if_rdata", 64'(if_rdata), 64'd0);
        chk("rma_d_rdata",  64'(d_rdata), 64'd0);
        chk("rma_acks",     64'({if_ack, d_ack}), 64'd0);
        RST = 1'b0; exp_if = '0; exp_d = '0;
        repeat (6) @(negedge clk);
        chk("rma_still_idle", 64'(busy), 64'd0);

        // Fetch request withdrawn during ACC still completes
        if_req = 1'b1; if_addr = 32'h600;
        expect_ack(1'b0, 1'b0, 32'h600, cyc + LAT + 1);
        @(negedge clk);
        if_req = 1'b0;
        wait_ack(1'b0);
        @(negedge clk);
        chk("wd_busy1", 64'(busy), 64'd0);
        @(negedge clk);
        chk("wd_busy2", 64'(busy), 64'd0);
        chk("wd_mem_en", 64'(mem_en), 64'd0);

        repeat (2) @(negedge clk);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-ported unified memory between the multi-cycle CPU's instruction-fetch port and its data (lw/sw) port. Latches one request at a time, runs a fixed-latency memory access, and returns a one-cycle acknowledge that the control unit uses to hold its current state as a stall. When both ports request in the same cycle, it alternates grants between them.

## Interface
Parameters:
- ADDR_W, 32, address width of both ports and the memory.
- DATA_W, 32, data width.
- MEM_LAT, 2, read access cycles; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle pulse; fetch completed.
- if_rdata  out  DATA_W  fetched word; valid from if_ack until the next if_ack.
- d_req  in  1  data request; held high until d_ack.
- d_we  in  1  1 = write (sw), 0 = read (lw).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  write data.
- d_ack  out  1  one-cycle pulse; data access completed.
- d_rdata  out  DATA_W  read word; valid from d_ack until the next read d_ack.
- mem_en  out  1  memory enable.
- mem_we  out  1  memory write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid by the end of the last access cycle.
- busy  out  1  high whenever state is not IDLE.

## Operation
- FSM states:
  - IDLE: samples requests.
  - ACC: memory access in progress.
  - RESP: ack pulse.
- IDLE transitions:
  - No request: stay in IDLE.
  - One request: grant it, latch its address, we and wdata into registers, clear the cycle counter, go to ACC.
  - Both request: grant the port NOT granted last. last_grant updates on every grant.
  - Fetch requests are always reads. if_* has no write path.
- ACC:
  - mem_en=1. mem_addr and mem_wdata come from the latched registers.
  - Write: mem_we=1 for exactly one ACC cycle, then go to RESP. mem_rdata is ignored.
  - Read: mem_we=0. The counter counts 0..MEM_LAT-1. On count MEM_LAT-1, capture mem_rdata into the granted port's rdata register, then go to RESP.
- RESP:
  - mem_en=0. The granted port's ack=1 for this cycle only.
  - Always return to IDLE. No request is sampled in RESP.
- The other port's rdata register is never modified by an access it was not granted.
- Request inputs changing during ACC or RESP are ignored because the request is latched.
- A req dropped before ack does not abort the access. It completes and ack still pulses.
- mem_addr and mem_wdata hold their last value when mem_en=0.

## Timing
- Reset values:
  - State IDLE.
  - last_grant = fetch, so data wins the first contention.
  - Counter 0.
  - if_ack=0, d_ack=0, if_rdata=0, d_rdata=0.
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0.
- Read latency (request seen in IDLE at cycle 0):
  - ACC occupies cycles 1..MEM_LAT.
  - ack at cycle MEM_LAT+1.
- Write latency: ACC at cycle 1, ack at cycle 2.
- Minimum request-to-request spacing is MEM_LAT+2 cycles for reads and 3 cycles for writes. A req held high after ack is regranted in the IDLE cycle following RESP.
- Reset asserted in any state: on the next edge go to IDLE with all outputs at reset values. No ack is issued and no pending mem_we completes.
- Reset has priority over every transition.
- All outputs come from registers or from decoding the state. There is no combinational path from req to mem_* or to ack.

## Test plan
- Single read, MEM_LAT=2: if_req, if_addr=0x10, mem_rdata=0xDEADBEEF.
  - Required: mem_en high for cycles 1–2 with mem_addr=0x10 and mem_we=0.
  - Required: if_ack pulses at cycle 3 with if_rdata=0xDEADBEEF; d_rdata stays 0.
- Write: d_req, d_we=1, d_addr=0x40, d_wdata=0x12345678.
  - Required: mem_we=1 and mem_en=1 for exactly cycle 1 with those values.
  - Required: d_ack at cycle 2; d_rdata unchanged.
- Contention: if_req and d_req both held high continuously, all reads.
  - Required grant order: data, fetch, data, fetch.
  - Required: acks spaced MEM_LAT+2 cycles apart, alternating ports.
- Back-to-back: d_req held high for two lw with d_addr changed immediately after the first d_ack.
  - Required: the second access uses the new address.
  - Required: the first d_rdata is held until the second d_ack.
- Reset mid-access: RST asserted in the first ACC cycle of a read.
  - Required: next cycle IDLE, mem_en=0, busy=0, rdata registers 0.
  - Required: no ack ever pulses for the aborted read.
- Withdrawn request: if_req dropped during ACC.
  - Required: the access completes and if_ack still pulses at cycle MEM_LAT+1.
  - Required: arbiter then idles with busy=0.
